// File: rtl/cu_command_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cu_command_arbiter
// Description : Four-way command arbiter between the compute-unit control
//               stage and the AFU command path. Each requester (read, write,
//               prefetch-read, prefetch-write) owns a FIFO. One command per
//               cycle is granted under a credit limit and issued on a single
//               registered command stream. Per-requester full, almost-full
//               and empty flags provide upstream backpressure.
// Options     : CU_ARBITER_FIXED_PRIORITY_EN - when defined, the lowest
//               requester index always wins. Default is round-robin.
// Revision    : 1.0 - initial release
// ============================================================================

package cu_command_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [7:0]  command;
        logic [31:0] address;
        logic [7:0]  size;
        logic [7:0]  tag;
    } CommandBufferLine;

endpackage

module cu_command_arbiter
    import cu_command_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH         = 16,
    parameter int ALMOST_FULL_MARGIN = 4,
    parameter int CREDIT_BITS        = 8
) (
    input  logic                   i_clock,
    input  logic                   i_rstn,
    input  logic                   i_enabled_in,
    input  CommandBufferLine       i_read_command,
    input  CommandBufferLine       i_write_command,
    input  CommandBufferLine       i_prefetch_read_command,
    input  CommandBufferLine       i_prefetch_write_command,
    input  logic [CREDIT_BITS-1:0] i_credit_init,
    input  logic                   i_credit_load,
    input  logic                   i_credit_return,
    output CommandBufferLine       o_command,
    output logic [3:0]             o_fifo_full,
    output logic [3:0]             o_fifo_almost_full,
    output logic [3:0]             o_fifo_empty,
    output logic [CREDIT_BITS-1:0] o_credits_available
);

    localparam int                     c_NUM_REQ    = 4;
    localparam int                     c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                     c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]     c_FULL_LEVEL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]     c_AF_LEVEL   = c_CNT_W'(FIFO_DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [CREDIT_BITS-1:0] c_CREDIT_MAX = '1;

    logic                                r_enabled;
    CommandBufferLine [c_NUM_REQ-1:0]    w_cmd_in;
    CommandBufferLine [c_NUM_REQ-1:0]    w_head;
    logic [c_NUM_REQ-1:0]                w_nonempty;
    logic [c_NUM_REQ-1:0]                w_full_now;
    logic [c_NUM_REQ-1:0]                w_push;
    logic [c_NUM_REQ-1:0]                w_pop;
    logic [c_NUM_REQ-1:0]                w_drop;
    logic [c_NUM_REQ-1:0]                w_eligible;
    logic                                w_grant_valid;
    logic [1:0]                          w_grant_idx;
    CommandBufferLine                    w_issue;
    CommandBufferLine                    r_command;
    logic [c_NUM_REQ-1:0]                r_overflow;
    logic [CREDIT_BITS-1:0]              r_credits;
    logic                                r_credit_return_q;
    logic                                w_credits_nonzero;

    // Requester index order: 0 read, 1 write, 2 prefetch-read, 3 prefetch-write.
    assign w_cmd_in = {i_prefetch_write_command, i_prefetch_read_command,
                       i_write_command, i_read_command};

    // Block enable is sampled once before it gates any activity.
    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_enabled <= 1'b0;
        end else begin
            r_enabled <= i_enabled_in;
        end
    end

    // ------------------------------------------------------------------------
    // Per-requester FIFOs
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_NUM_REQ; gi++) begin : g_req
            CommandBufferLine     r_mem [FIFO_DEPTH];
            logic [c_PTR_W-1:0]   r_wr_ptr;
            logic [c_PTR_W-1:0]   r_rd_ptr;
            logic [c_CNT_W-1:0]   r_count;
            logic [c_CNT_W-1:0]   w_count_next;
            logic                 r_full;
            logic                 r_almost_full;
            logic                 r_empty;

            assign w_nonempty[gi] = (r_count != '0);
            assign w_full_now[gi] = (r_count == c_FULL_LEVEL);
            assign w_pop[gi]      = w_grant_valid && (w_grant_idx == 2'(gi));
            // A pop from a full FIFO frees the slot for a push in the same cycle.
            assign w_push[gi]     = r_enabled && w_cmd_in[gi].valid &&
                                    (!w_full_now[gi] || w_pop[gi]);
            assign w_drop[gi]     = r_enabled && w_cmd_in[gi].valid &&
                                    w_full_now[gi] && !w_pop[gi];
            assign w_head[gi]     = r_mem[r_rd_ptr];

            // Occupancy after this cycle's push and pop.
            always_comb begin
                w_count_next = r_count;
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   w_count_next = r_count + c_CNT_W'(1);
                    2'b01:   w_count_next = r_count - c_CNT_W'(1);
                    default: w_count_next = r_count;
                endcase
            end

            // Payload storage; occupancy gates every read so no reset is needed.
            always_ff @(posedge i_clock) begin
                if (w_push[gi]) begin
                    r_mem[r_wr_ptr] <= w_cmd_in[gi];
                end
            end

            // Pointers, occupancy and status flags derived from post-update occupancy.
            always_ff @(posedge i_clock or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_wr_ptr      <= '0;
                    r_rd_ptr      <= '0;
                    r_count       <= '0;
                    r_full        <= 1'b0;
                    r_almost_full <= 1'b0;
                    r_empty       <= 1'b1;
                end else begin
                    if (w_push[gi]) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                    end
                    r_count       <= w_count_next;
                    r_full        <= (w_count_next == c_FULL_LEVEL);
                    r_almost_full <= (w_count_next >= c_AF_LEVEL);
                    r_empty       <= (w_count_next == '0);
                end
            end

            assign o_fifo_full[gi]        = r_full;
            assign o_fifo_almost_full[gi] = r_almost_full;
            assign o_fifo_empty[gi]       = r_empty;
        end
    endgenerate

    // Drops into a full FIFO are remembered until reset for diagnostics.
    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | w_drop;
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    assign w_credits_nonzero = (r_credits != '0);
    assign w_eligible        = (r_enabled && w_credits_nonzero) ? w_nonempty : '0;

`ifdef CU_ARBITER_FIXED_PRIORITY_EN
    // Fixed priority: scan from the highest index down so the lowest one sticks.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        for (int k = c_NUM_REQ - 1; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = 2'(k);
            end
        end
    end
`else
    logic [1:0] r_rr_last;
    logic [1:0] w_rr_cand;

    // Round-robin: search starts just after the last winner and wraps mod 4.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        w_rr_cand     = 2'd0;
        for (int k = 1; k <= c_NUM_REQ; k++) begin
            w_rr_cand = r_rr_last + 2'(k);
            if (!w_grant_valid && w_eligible[w_rr_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_rr_cand;
            end
        end
    end

    // Remember the most recent winner; reset value makes requester 0 first.
    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rr_last <= 2'd3;
        end else if (w_grant_valid) begin
            r_rr_last <= w_grant_idx;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Issue
    // ------------------------------------------------------------------------
    // Winner's head entry with its valid bit forced on.
    always_comb begin
        w_issue       = w_head[w_grant_idx];
        w_issue.valid = 1'b1;
    end

    // Registered command stream; idle cycles drive all zeros.
    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_command <= '0;
        end else if (w_grant_valid) begin
            r_command <= w_issue;
        end else begin
            r_command <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Credits
    // ------------------------------------------------------------------------
    // Returns pass through one flop, so a return frees a grant two edges later.
    // Load beats grant/return; grant plus return cancel; returns saturate.
    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_credits         <= '0;
            r_credit_return_q <= 1'b0;
        end else begin
            r_credit_return_q <= i_credit_return;
            if (r_enabled) begin
                if (i_credit_load) begin
                    r_credits <= i_credit_init;
                end else begin
                    case ({w_grant_valid, r_credit_return_q})
                        2'b10: r_credits <= r_credits - CREDIT_BITS'(1);
                        2'b01: begin
                            if (r_credits != c_CREDIT_MAX) begin
                                r_credits <= r_credits + CREDIT_BITS'(1);
                            end
                        end
                        default: r_credits <= r_credits;
                    endcase
                end
            end
        end
    end

    assign o_command           = r_command;
    assign o_credits_available = r_credits;

endmodule

`default_nettype wire

// File: doc/cu_command_arbiter.md
# cu_command_arbiter

Four-way command arbiter between the compute-unit control stage and the AFU command path. It captures the read, write, prefetch-read and prefetch-write `CommandBufferLine` streams into per-requester FIFOs. It grants one command per cycle under a credit limit from the PSL command-room count, and drives a single registered command stream toward the command issue logic. Per-requester full/almost-full flags give the upstream engines their backpressure.

## Interface
- `FIFO_DEPTH`, 16: entries per requester FIFO; power of two, ≥4.
- `ALMOST_FULL_MARGIN`, 4: almost-full asserts when occupancy ≥ `FIFO_DEPTH − ALMOST_FULL_MARGIN`.
- `CREDIT_BITS`, 8: width of the credit counter.
- `clock`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `enabled_in`  in  1: block enable; registered once internally.
- `read_command_in`  in  CommandBufferLine: requester 0; accepted when `.valid`=1.
- `write_command_in`  in  CommandBufferLine: requester 1.
- `prefetch_read_command_in`  in  CommandBufferLine: requester 2.
- `prefetch_write_command_in`  in  CommandBufferLine: requester 3.
- `credit_init`  in  CREDIT_BITS: initial credit count (command room).
- `credit_load`  in  1: pulse; loads `credit_init` into the credit counter.
- `credit_return`  in  1: pulse; returns one credit.
- `command_out`  out  CommandBufferLine: granted command; `.valid` marks issue.
- `fifo_full`  out  4: per-requester full, bit i = requester i.
- `fifo_almost_full`  out  4: per-requester almost-full.
- `fifo_empty`  out  4: per-requester empty.
- `credits_available`  out  CREDIT_BITS: current credit count.

## Operation
- Enable:
  - `enabled` is `enabled_in` delayed by one flop.
  - When `enabled`=0, no pushes, pops or grants take place.
  - While disabled, the credit counter and FIFO contents hold.
- Push:
  - Requester i pushes when its input `.valid`=1 and `enabled`=1.
  - A push into a full FIFO is dropped.
  - A dropped push sets the sticky `overflow` bit i. It is internal, cleared only by reset, and visible to the bench.
- Arbitration:
  - Eligible set = requesters with a non-empty FIFO, only when credits > 0.
  - Round-robin pointer `rr_last` (2 bits): search starts at `rr_last+1` mod 4.
  - The first eligible requester wins; `rr_last` is then set to the winner.
  - At most one grant per cycle.
- Issue:
  - The winner's head entry is popped and registered into `command_out` with `.valid`=1.
  - Otherwise `command_out` is driven to 0.
- Credits:
  - Each grant decrements the counter; each `credit_return` increments it.
  - A grant and a return in the same cycle leave the counter unchanged.
  - `credit_load` has priority over both and loads `credit_init` directly.
  - The counter saturates at 2^CREDIT_BITS−1. A return at saturation is ignored.
- FIFO arithmetic:
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth.
  - The occupancy counter is one bit wider.
  - A simultaneous push and pop on the same FIFO leaves occupancy unchanged. This is legal even when the FIFO is full, because the pop frees the slot in the same cycle.

## Timing
- Reset values:
  - `command_out`=0, `fifo_full`=0, `fifo_almost_full`=0, `fifo_empty`=4'b1111.
  - `credits_available`=0, `rr_last`=3 (so requester 0 is searched first).
  - All pointers and occupancy counters = 0.
- Latency and throughput:
  - Input accepted at edge N; earliest `command_out.valid` at edge N+1, given an empty FIFO, credits > 0 and a win.
  - Sustained throughput is one command per cycle.
- Status flags:
  - `fifo_full`, `fifo_almost_full` and `fifo_empty` are registered from occupancy after the push/pop of the current cycle.
  - Upstream must stop driving `.valid` in the cycle after `fifo_almost_full` rises. The margin covers the upstream pipeline flops.
- Zero credits: no grant takes place. A `credit_return` at edge N enables a grant whose `command_out` appears at edge N+2.
- Reset mid-operation: all FIFO contents are discarded and `command_out` clears asynchronously.

## Configuration
- `CU_ARBITER_FIXED_PRIORITY_EN`:
  - Defined: fixed priority, lowest requester index wins (read > write > prefetch-read > prefetch-write); `rr_last` is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset then idle: `command_out`=0, `fifo_empty`=4'b1111 and `credits_available`=0 on every cycle.
- `credit_init`=8 with `credit_load`, then one read command at edge 10 → `command_out.valid` at edge 11 with identical payload, and `credits_available`=7.
- All four requesters push 3 commands each in the same cycles, with 64 credits:
  - Round-robin: grant order 0,1,2,3,0,1,2,3,0,1,2,3 with no gaps.
  - With `CU_ARBITER_FIXED_PRIORITY_EN`: order 0,0,0,1,1,1,2,2,2,3,3,3.
- Credits = 2 with 5 queued write commands: exactly 2 issue, then stall. Each `credit_return` pulse releases exactly one more command, 2 cycles later.
- Fill requester 1 with no credits:
  - `fifo_almost_full[1]` rises at occupancy 12 and `fifo_full[1]` at 16.
  - A 17th push is dropped and `overflow[1]`=1.
  - After loading credits, exactly 16 commands drain in FIFO order.
- Assert `rstn` low mid-stream with 6 queued commands: outputs return to reset values immediately. After release, no stale command issues even with credits reloaded.
